layer_serializer: RTL

LAYER_SERIALIZER -- requirements
Module: layer_serializer

---
 rtl/layer_serializer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/layer_serializer.sv
// layer_serializer: captures a full layer of neuron outputs once every in_valid
// strobe is high, then streams the elements out one per cycle, neuron 0 first.
// Optional feature macro MAXFIND_EN adds a signed running-argmax over each
// stream, reported on max_idx / max_valid.
module layer_serializer #(
  parameter int num_neurons = 30,
  parameter int data_width  = 16,
  localparam int unsigned CNT_W = (num_neurons > 1) ? $clog2(num_neurons) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [num_neurons-1:0]            in_valid,
  input  logic [num_neurons*data_width-1:0] in_data,
  output logic [data_width-1:0]             out_data,
  output logic                              out_valid,
  output logic                              busy,
`ifdef MAXFIND_EN
  output logic [CNT_W-1:0]                  max_idx,
  output logic                              max_valid,
`endif
  output logic                              overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(num_neurons - 1);

  logic [0:0]                        state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [num_neurons*data_width-1:0] hold_q, hold_d;
  logic [data_width-1:0]             out_data_q, out_data_d;
  logic                              out_valid_q, out_valid_d;
  logic                              busy_q, busy_d;
  logic                              overrun_q, overrun_d;
  logic                              capture;
  logic                              last;

  // Next-state: capture / shift / back-to-back reload / overrun detection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    overrun_d  = overrun_q;
    capture    = &in_valid;
    last       = (cnt_q == CNT_LAST);
    if (rst) begin
      state_d   = IDLE;
      cnt_d     = '0;
      hold_d    = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            hold_d  = in_data;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            cnt_d = '0;
            if (capture) begin
              hold_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (capture) begin
              overrun_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs reflect the state/element being entered this edge
  always_comb begin
    out_valid_d = (state_d == SHIFT);
    busy_d      = (state_d == SHIFT);
    out_data_d  = '0;
    if (out_valid_d) begin
      out_data_d = hold_d[int'(cnt_d)*data_width +: data_width];
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    hold_q      <= hold_d;
    out_data_q  <= out_data_d;
    out_valid_q <= out_valid_d;
    busy_q      <= busy_d;
    overrun_q   <= overrun_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

`ifdef MAXFIND_EN
  logic [data_width-1:0] run_max_q, run_max_d;
  logic [CNT_W-1:0]      run_idx_q, run_idx_d;
  logic [CNT_W-1:0]      max_idx_q, max_idx_d;
  logic                  max_valid_q, max_valid_d;

  // Running signed max over the element on out_data; strict > keeps lowest index on ties
  always_comb begin
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_idx_d   = max_idx_q;
    max_valid_d = 1'b0;
    if (rst) begin
      run_max_d = '0;
      run_idx_d = '0;
      max_idx_d = '0;
    end else if (state_q == SHIFT) begin
      if ((cnt_q == '0) || ($signed(out_data_q) > $signed(run_max_q))) begin
        run_max_d = out_data_q;
        run_idx_d = cnt_q;
      end
      if (last) begin
        max_valid_d = 1'b1;
        max_idx_d   = run_idx_d;
      end
    end
  end

  // Argmax registers
  always_ff @(posedge clk) begin
    run_max_q   <= run_max_d;
    run_idx_q   <= run_idx_d;
    max_idx_q   <= max_idx_d;
    max_valid_q <= max_valid_d;
  end

  assign max_idx   = max_idx_q;
  assign max_valid = max_valid_q;
`endif

endmodule
